// File: rtl/eq_band_scheduler_if.sv
// Bundle of sample-in, gain-programming, FIR-engine and mixed-output signals
// for the equalizer band scheduler.
interface eq_band_scheduler_if #(
  parameter int DW = 16,
  parameter int GW = 16
);
  logic                 sample_valid;
  logic signed [DW-1:0] sample_in;
  logic                 gain_wr;
  logic [2:0]           gain_addr;
  logic signed [GW-1:0] gain_data;
  logic                 fir_start;
  logic [2:0]           fir_band;
  logic signed [DW-1:0] fir_x;
  logic                 fir_done;
  logic signed [DW-1:0] fir_y;
  logic                 y_valid;
  logic signed [DW-1:0] y_out;
  logic                 busy;
  logic                 overrun;
  logic                 timeout_err;

  modport master (
    input  sample_valid, sample_in, gain_wr, gain_addr, gain_data, fir_done, fir_y,
    output fir_start, fir_band, fir_x, y_valid, y_out, busy, overrun, timeout_err
  );

  modport slave (
    output sample_valid, sample_in, gain_wr, gain_addr, gain_data, fir_done, fir_y,
    input  fir_start, fir_band, fir_x, y_valid, y_out, busy, overrun, timeout_err
  );
endinterface

// File: rtl/eq_band_scheduler.sv
// Time-shares one FIR engine across N_BAND equalizer bands per sample, scales
// each band result by its Q2.14 gain, accumulates, and emits a saturated mix.
module eq_band_scheduler #(
  parameter int N_BAND  = 5,
  parameter int DW      = 16,
  parameter int GW      = 16,
  parameter int TIMEOUT = 1023
) (
  input logic                  i_clk,
  input logic                  i_rst,
  eq_band_scheduler_if.master  bus
);
  localparam int PW   = DW + GW;
  localparam int AW   = DW + GW + 3;
  localparam int FRAC = GW - 2;
  localparam int WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [2:0]           LAST_BAND = 3'(N_BAND - 1);
  localparam logic [WDW-1:0]       WD_MAX    = WDW'(TIMEOUT);
  localparam logic signed [GW-1:0] UNITY     = GW'(1 << FRAC);
  localparam logic signed [AW-1:0] SAT_MAX   = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN   = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [2:0]           r_state;
  logic [2:0]           r_band;
  logic signed [AW-1:0] r_acc;
  logic signed [PW-1:0] r_prod;
  logic [WDW-1:0]       r_wdog;
  logic signed [GW-1:0] r_gain [N_BAND];
  logic                 r_fir_start;
  logic [2:0]           r_fir_band;
  logic signed [DW-1:0] r_fir_x;
  logic                 r_y_valid;
  logic signed [DW-1:0] r_y_out;
  logic                 r_overrun;
  logic                 r_timeout;

  logic signed [GW-1:0] w_gain;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_ext;
  logic signed [AW-1:0] w_shift;
  logic signed [DW-1:0] w_sat;

  // Operands widened to the product width so the multiply is a full signed DWxGW.
  assign w_gain     = r_gain[r_band];
  assign w_prod     = $signed({{GW{bus.fir_y[DW-1]}}, bus.fir_y}) *
                      $signed({{DW{w_gain[GW-1]}}, w_gain});
  assign w_prod_ext = $signed({{(AW-PW){r_prod[PW-1]}}, r_prod});
  assign w_shift    = r_acc >>> FRAC;

  always_comb begin
    w_sat = w_shift[DW-1:0];
    if (w_shift > SAT_MAX) begin
      w_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (w_shift < SAT_MIN) begin
      w_sat = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_band      <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_wdog      <= '0;
      r_fir_start <= 1'b0;
      r_fir_band  <= '0;
      r_fir_x     <= '0;
      r_y_valid   <= 1'b0;
      r_y_out     <= '0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      for (int unsigned i = 0; i < N_BAND; i++) begin
        r_gain[i] <= UNITY;
      end
    end else begin
      r_fir_start <= 1'b0;
      r_y_valid   <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= bus.sample_valid && (r_state != S_IDLE);

      // Out-of-range addresses match no entry and are dropped.
      for (int unsigned i = 0; i < N_BAND; i++) begin
        if (bus.gain_wr && (bus.gain_addr == 3'(i))) begin
          r_gain[i] <= bus.gain_data;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.sample_valid) begin
            r_fir_x <= bus.sample_in;
            r_band  <= '0;
            r_acc   <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_fir_start <= 1'b1;
          r_fir_band  <= r_band;
          r_wdog      <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // A done on the final watchdog cycle still counts as a good result.
          if (bus.fir_done) begin
            r_prod  <= w_prod;
            r_state <= S_ACC;
          end else if (r_wdog == WD_MAX) begin
            r_prod    <= '0;
            r_timeout <= 1'b1;
            r_state   <= S_ACC;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end
        S_ACC: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_band == LAST_BAND) begin
            r_state <= S_OUT;
          end else begin
            r_band  <= r_band + 3'd1;
            r_state <= S_ISSUE;
          end
        end
        S_OUT: begin
          r_y_out   <= w_sat;
          r_y_valid <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fir_start   = r_fir_start;
  assign bus.fir_band    = r_fir_band;
  assign bus.fir_x       = r_fir_x;
  assign bus.y_valid     = r_y_valid;
  assign bus.y_out       = r_y_out;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.overrun     = r_overrun;
  assign bus.timeout_err = r_timeout;
endmodule
